// File: rtl/simulador_drone_n.sv
// simulador_drone_n: parametrised drone game core (vertical drone, scrolling map, LFSR obstacles, lives).
// Optional pause support (port pausa, state PAUSADO) is built when DRONE_PAUSA_EN is defined.
module simulador_drone_n #(
    parameter int unsigned ALTURA      = 4,
    parameter int unsigned COMPRIMENTO = 16,
    parameter int unsigned MAX_VIDAS   = 3,
    parameter int unsigned T_LENTO     = 1000,
    parameter int unsigned T_MEDIO     = 500,
    parameter int unsigned T_RAPIDO    = 250,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    input  logic [1:0]                     controle,
    input  logic                           confirma,
`ifdef DRONE_PAUSA_EN
    input  logic                           pausa,
`endif
    output logic                           venceu,
    output logic                           perdeu,
    output logic [$clog2(COMPRIMENTO)-1:0] db_posicao_horizontal,
    output logic [$clog2(ALTURA)-1:0]      db_posicao_vertical,
    output logic [ALTURA-1:0]              db_obstaculos,
    output logic [2:0]                     db_vidas,
    output logic [1:0]                     db_modo,
    output logic [3:0]                     db_estado
);

    localparam int unsigned HW    = $clog2(COMPRIMENTO);
    localparam int unsigned VW    = $clog2(ALTURA);
    localparam int unsigned T_A   = (T_LENTO > T_MEDIO) ? T_LENTO : T_MEDIO;
    localparam int unsigned T_MAX = (T_A > T_RAPIDO) ? T_A : T_RAPIDO;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    localparam logic [HW-1:0] H_FIM  = HW'(COMPRIMENTO - 1);
    localparam logic [VW-1:0] V_TOPO = VW'(ALTURA - 1);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESCOLHE_MODO = 4'd1,
        ESCOLHE_VIDA = 4'd2,
        PREPARA      = 4'd3,
        JOGANDO      = 4'd4,
        CHECA        = 4'd5,
        COLIDIU      = 4'd6,
        VENCEU       = 4'd7,
        PERDEU       = 4'd8
`ifdef DRONE_PAUSA_EN
        , PAUSADO    = 4'd9
`endif
    } estado_t;

    estado_t         estado, proximo;
    logic            confirma_d;
    logic            pulso;
    logic [TW-1:0]   timer, t_fim;
    logic [HW-1:0]   h, h_prox;
    logic [VW-1:0]   v;
    logic [ALTURA-1:0] mask, mask_prox;
    logic [2:0]      vidas, vidas_sel;
    logic [1:0]      modo;
    logic [7:0]      lfsr, lfsr_prox;
    logic            invul;
    logic            ativo, passo, cmd_sobe, cmd_desce, mover;
    int unsigned     linha;

    assign pulso = confirma & ~confirma_d;

`ifdef DRONE_PAUSA_EN
    assign ativo = (estado == JOGANDO) && !pausa;
`else
    assign ativo = (estado == JOGANDO);
`endif

    always_comb begin
        t_fim = TW'(T_RAPIDO - 1);
        case (modo)
            2'd0:    t_fim = TW'(T_LENTO - 1);
            2'd1:    t_fim = TW'(T_MEDIO - 1);
            default: t_fim = TW'(T_RAPIDO - 1);
        endcase
    end

    assign passo     = ativo && (timer == t_fim);
    assign cmd_sobe  = pulso && (controle == 2'b01);
    assign cmd_desce = pulso && (controle == 2'b10);
    assign mover     = ativo && (cmd_sobe || cmd_desce);

    assign lfsr_prox = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign h_prox    = h + HW'(1);

    // The obstacle row comes from the LFSR value the step is about to load; the final column is always clear.
    always_comb begin
        mask_prox = '0;
        linha     = 32'(lfsr_prox) % ALTURA;
        for (int unsigned r = 0; r < ALTURA; r++) begin
            mask_prox[r] = (linha == r);
        end
        if (h_prox == H_FIM) begin
            mask_prox = '0;
        end
    end

    always_comb begin
        vidas_sel = {1'b0, controle} + 3'd1;
        if ({1'b0, controle} >= 3'(MAX_VIDAS)) begin
            vidas_sel = 3'(MAX_VIDAS);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:      if (iniciar) proximo = ESCOLHE_MODO;
            ESCOLHE_MODO: if (pulso) proximo = ESCOLHE_VIDA;
            ESCOLHE_VIDA: if (pulso) proximo = PREPARA;
            PREPARA:      proximo = JOGANDO;
            JOGANDO: begin
`ifdef DRONE_PAUSA_EN
                if (pausa) proximo = PAUSADO;
                else
`endif
                if (passo || mover) proximo = CHECA;
            end
            CHECA: begin
                if (h == H_FIM) proximo = VENCEU;
                else if (mask[v] && !invul) proximo = COLIDIU;
                else proximo = JOGANDO;
            end
            COLIDIU:      proximo = (vidas <= 3'd1) ? PERDEU : JOGANDO;
            VENCEU:       if (iniciar) proximo = ESCOLHE_MODO;
            PERDEU:       if (iniciar) proximo = ESCOLHE_MODO;
`ifdef DRONE_PAUSA_EN
            PAUSADO:      if (!pausa) proximo = JOGANDO;
`endif
            default:      proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            confirma_d <= 1'b0;
            timer      <= '0;
            h          <= '0;
            v          <= '0;
            mask       <= '0;
            vidas      <= '0;
            modo       <= '0;
            lfsr       <= SEED;
            invul      <= 1'b0;
        end else begin
            confirma_d <= confirma;
            case (estado)
                ESCOLHE_MODO: if (pulso) modo <= controle;
                ESCOLHE_VIDA: if (pulso) vidas <= vidas_sel;
                PREPARA: begin
                    h     <= '0;
                    v     <= '0;
                    mask  <= '0;
                    timer <= '0;
                    lfsr  <= SEED;
                    invul <= 1'b0;
                end
                JOGANDO: begin
                    if (ativo) begin
                        if (passo) begin
                            timer <= '0;
                            h     <= h_prox;
                            lfsr  <= lfsr_prox;
                            mask  <= mask_prox;
                            invul <= 1'b0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                        if (cmd_sobe && (v != V_TOPO)) v <= v + VW'(1);
                        else if (cmd_desce && (v != '0)) v <= v - VW'(1);
                    end
                end
                COLIDIU: begin
                    vidas <= vidas - 3'd1;
                    invul <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign venceu                = (estado == VENCEU);
    assign perdeu                = (estado == PERDEU);
    assign db_posicao_horizontal = h;
    assign db_posicao_vertical   = v;
    assign db_obstaculos         = mask;
    assign db_vidas              = vidas;
    assign db_modo               = modo;
    assign db_estado             = estado;

endmodule

// File: tb/tb_simulador_drone_n.sv
// Directed testbench for simulador_drone_n: small grid, short fast-mode timer, hand-computed expectations.
module tb_simulador_drone_n;

    localparam int unsigned ALTURA      = 4;
    localparam int unsigned COMPRIMENTO = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [1:0] controle = 2'b00;
    logic       confirma = 1'b0;
`ifdef DRONE_PAUSA_EN
    logic       pausa = 1'b0;
`endif
    logic       venceu, perdeu;
    logic [1:0] db_h, db_v;
    logic [3:0] db_obst;
    logic [2:0] db_vidas;
    logic [1:0] db_modo;
    logic [3:0] db_estado;

    int n_testes = 0;
    int n_falhas = 0;

    simulador_drone_n #(
        .ALTURA(ALTURA),
        .COMPRIMENTO(COMPRIMENTO),
        .MAX_VIDAS(3),
        .T_LENTO(40),
        .T_MEDIO(6),
        .T_RAPIDO(2),
        .SEED(8'hA5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .controle(controle),
        .confirma(confirma),
`ifdef DRONE_PAUSA_EN
        .pausa(pausa),
`endif
        .venceu(venceu),
        .perdeu(perdeu),
        .db_posicao_horizontal(db_h),
        .db_posicao_vertical(db_v),
        .db_obstaculos(db_obst),
        .db_vidas(db_vidas),
        .db_modo(db_modo),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic confere(input string tag, input int obtido, input int esperado);
        n_testes++;
        if (obtido != esperado) begin
            n_falhas++;
            $display("FAIL %s: got %0d expected %0d", tag, obtido, esperado);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic move(input logic [1:0] c);
        controle = c;
        confirma = 1'b1;
        tick(1);
        confirma = 1'b0;
        controle = 2'b00;
        tick(1);
    endtask

    // Expects ESCOLHE_MODO on entry; leaves the core in JOGANDO with timer 0.
    task automatic inicia_jogo(input logic [1:0] c_modo, input logic [1:0] c_vida,
                               input int modo_esp, input int vidas_esp);
        controle = c_modo;
        confirma = 1'b1;
        tick(1);
        confirma = 1'b0;
        confere("modo", db_modo, modo_esp);
        confere("estado_escolhe_vida", db_estado, 2);
        tick(1);
        controle = c_vida;
        confirma = 1'b1;
        tick(1);
        confirma = 1'b0;
        controle = 2'b00;
        confere("vidas_sel", db_vidas, vidas_esp);
        confere("estado_prepara", db_estado, 3);
        tick(1);
        confere("estado_jogando", db_estado, 4);
        confere("h_inicio", db_h, 0);
        confere("v_inicio", db_v, 0);
        confere("mask_inicio", db_obst, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(2);
        confere("rst_estado", db_estado, 0);
        confere("rst_h", db_h, 0);
        confere("rst_v", db_v, 0);
        confere("rst_obst", db_obst, 0);
        confere("rst_vidas", db_vidas, 0);
        confere("rst_modo", db_modo, 0);
        confere("rst_venceu", venceu, 0);
        confere("rst_perdeu", perdeu, 0);
        reset = 1'b0;
        tick(1);
        confere("idle_estado", db_estado, 0);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        confere("iniciar", db_estado, 1);

        // Selection (modo 2, 2 lives) then idle play to a win
        inicia_jogo(2'b10, 2'b01, 2, 2);
        tick(2);
        confere("h1", db_h, 1);
        confere("mask_h1", db_obst, 4'b0100);
        confere("checa_h1", db_estado, 5);
        tick(1);
        confere("volta_jogando", db_estado, 4);
        tick(2);
        confere("h2", db_h, 2);
        confere("mask_h2", db_obst, 4'b0010);
        tick(1);
        tick(2);
        confere("h3", db_h, 3);
        confere("mask_h3", db_obst, 0);
        tick(1);
        confere("venceu", venceu, 1);
        confere("estado_venceu", db_estado, 7);
        tick(3);
        confere("venceu_hold", venceu, 1);
        confere("h_hold", db_h, 3);
        confere("vidas_sem_colisao", db_vidas, 2);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        confere("reinicio_venceu", db_estado, 1);
        confere("venceu_limpo", venceu, 0);

        // Collision with invulnerability (modo 1, T=6)
        inicia_jogo(2'b01, 2'b01, 1, 2);
        move(2'b01);
        move(2'b01);
        confere("v_sobe2", db_v, 2);
        tick(3);
        confere("h_antes_passo", db_h, 0);
        tick(1);
        confere("h_colisao", db_h, 1);
        confere("checa_colisao", db_estado, 5);
        tick(1);
        confere("colidiu", db_estado, 6);
        tick(1);
        confere("vidas_apos_colisao", db_vidas, 1);
        confere("jogando_apos_colisao", db_estado, 4);
        move(2'b10);
        confere("v_desce", db_v, 1);
        move(2'b01);
        confere("v_volta", db_v, 2);
        confere("invul_estado", db_estado, 4);
        confere("invul_vidas", db_vidas, 1);

        // Reset mid-game has priority
        reset = 1'b1;
        tick(1);
        confere("rst_meio_estado", db_estado, 0);
        confere("rst_meio_h", db_h, 0);
        confere("rst_meio_v", db_v, 0);
        confere("rst_meio_vidas", db_vidas, 0);
        confere("rst_meio_modo", db_modo, 0);
        reset = 1'b0;
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        confere("iniciar2", db_estado, 1);

        // Loss with a single life: move + step in the same cycle
        inicia_jogo(2'b10, 2'b00, 2, 1);
        controle = 2'b01;
        confirma = 1'b1;
        tick(1);
        confirma = 1'b0;
        tick(1);
        confirma = 1'b1;
        tick(1);
        confirma = 1'b0;
        controle = 2'b00;
        confere("passo_e_move_h", db_h, 1);
        confere("passo_e_move_v", db_v, 2);
        confere("passo_e_move_estado", db_estado, 5);
        tick(1);
        confere("colidiu_final", db_estado, 6);
        tick(1);
        confere("vidas_zero", db_vidas, 0);
        confere("perdeu", perdeu, 1);
        confere("estado_perdeu", db_estado, 8);
        tick(3);
        confere("perdeu_hold", perdeu, 1);
        confere("perdeu_h_hold", db_h, 1);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        confere("reinicio_perdeu", db_estado, 1);
        confere("perdeu_limpo", perdeu, 0);

        // Saturation and edge detection (modo 0, long timer)
        inicia_jogo(2'b00, 2'b11, 0, 3);
        move(2'b10);
        confere("sat_baixo", db_v, 0);
        move(2'b11);
        confere("cmd_11_v", db_v, 0);
        confere("cmd_11_estado", db_estado, 4);
        move(2'b01);
        move(2'b01);
        move(2'b01);
        confere("v_topo", db_v, 3);
        move(2'b01);
        confere("sat_topo", db_v, 3);
        controle = 2'b10;
        confirma = 1'b1;
        tick(10);
        confirma = 1'b0;
        controle = 2'b00;
        tick(1);
        confere("confirma_mantido", db_v, 2);
        confere("h_lento", db_h, 0);
        for (int i = 0; i < 60 && db_h != 2'd1; i++) tick(1);
        confere("passo_lento", db_h, 1);
        confere("mask_lento", db_obst, 4'b0100);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
